// File: rtl/led_sr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_sr_pkg
// Purpose  : Shared LED codes, FSM encoding and blink evaluation for the
//            front-panel LED shift-register controller.
// Revision : 1.0 - initial release
// ============================================================================
package led_sr_pkg;

    localparam logic [1:0] LED_OFF  = 2'b00;
    localparam logic [1:0] LED_ON   = 2'b01;
    localparam logic [1:0] LED_SLOW = 2'b10;
    localparam logic [1:0] LED_FAST = 2'b11;

    localparam int PHASE_W        = 8;
    localparam int PHASE_SLOW_BIT = 4;
    localparam int PHASE_FAST_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_LATCH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic led_eval(input logic [1:0] code,
                                      input logic [PHASE_W-1:0] phase);
        case (code)
            LED_OFF:  return 1'b0;
            LED_ON:   return 1'b1;
            LED_SLOW: return phase[PHASE_SLOW_BIT];
            default:  return phase[PHASE_FAST_BIT];
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_sr_btn_deb.sv
`default_nettype none
// ============================================================================
// Module   : led_sr_btn_deb
// Purpose  : Per-frame button debouncer; accepts a level change after
//            BTN_DEB consecutive differing samples.
// Revision : 1.0 - initial release
// ============================================================================
module led_sr_btn_deb #(
    parameter int BTN_DEB = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_en,
    input  logic btn_in,
    output logic btn_val,
    output logic btn_stb
);

    localparam int                c_cnt_w    = $clog2(BTN_DEB + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BTN_DEB - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            btn_val <= 1'b0;
            btn_stb <= 1'b0;
        end else begin
            btn_stb <= 1'b0;
            if (sample_en) begin
                if (btn_in == btn_val) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_cnt_last) begin
                    r_cnt   <= '0;
                    btn_val <= ~btn_val;
                    btn_stb <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_sr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_sr_ctrl
// Purpose  : N-channel front-panel LED controller sharing the flash SPI pins
//            via request/grant, with button read-back on the latch line.
// Revision : 1.0 - initial release
// ============================================================================
module led_sr_ctrl
    import led_sr_pkg::*;
#(
    parameter int N_CH           = 2,
    parameter int TICK_LOG2_DIV  = 3,
    parameter int REFRESH_DIV    = 65536,
    parameter int BTN_DEB        = 4,
    parameter int LED_ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*N_CH-1:0] led_state,
    input  logic              run,
    output logic              spi_req,
    input  logic              spi_gnt,
    output logic              sr_clk,
    output logic              sr_mosi,
    output logic              sr_rclk,
    input  logic              btn_in,
    output logic              btn_val,
    output logic              btn_stb,
    output logic              active
);

    localparam int c_sr_w  = 2 * N_CH;
    localparam int c_ref_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_pre_w = TICK_LOG2_DIV + 1;
    localparam int c_bit_w = $clog2(c_sr_w);

    localparam logic [c_ref_w-1:0] c_ref_last   = c_ref_w'(REFRESH_DIV - 1);
    localparam logic [c_pre_w-1:0] c_half_last  = c_pre_w'((1 << TICK_LOG2_DIV) - 1);
    localparam logic [c_pre_w-1:0] c_latch_last = c_pre_w'((2 << TICK_LOG2_DIV) - 1);
    localparam logic [c_bit_w-1:0] c_bit_last   = c_bit_w'(c_sr_w - 1);
    localparam logic               c_inv        = (LED_ACTIVE_LOW != 0);

    state_t               r_state;
    logic [c_ref_w-1:0]   r_ref;
    logic [PHASE_W-1:0]   r_phase;
    logic [c_pre_w-1:0]   r_pre;
    logic [c_bit_w-1:0]   r_bit;
    logic [c_sr_w-1:0]    r_sh;

    logic                 w_frame_start;
    logic                 w_btn_sample;
    logic [c_sr_w-1:0]    w_word;

    assign w_frame_start = (r_ref == '0) && run;

    // Channel N_CH-1 lands in the MSBs so it leaves the shifter first.
    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_ch
            assign w_word[2*k+1] = led_eval(led_state[4*k+3 -: 2], r_phase) ^ c_inv;
            assign w_word[2*k]   = led_eval(led_state[4*k+1 -: 2], r_phase) ^ c_inv;
        end
    endgenerate

    // Button is only meaningful on the final latch cycle of a granted frame.
    assign w_btn_sample = (r_state == ST_LATCH) && spi_gnt && (r_pre == c_latch_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ref   <= '0;
            r_phase <= '0;
            r_pre   <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
            spi_req <= 1'b0;
            sr_clk  <= 1'b0;
            sr_mosi <= 1'b0;
            sr_rclk <= 1'b0;
            active  <= 1'b0;
        end else begin
            r_ref <= (r_ref == c_ref_last) ? '0 : r_ref + 1'b1;
            if (w_frame_start) begin
                r_phase <= r_phase + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_frame_start) begin
                        r_state <= ST_REQ;
                        spi_req <= 1'b1;
                        r_sh    <= w_word;
                    end
                end

                ST_REQ: begin
                    if (!run) begin
                        r_state <= ST_IDLE;
                        spi_req <= 1'b0;
                    end else if (spi_gnt) begin
                        r_state <= ST_SHIFT;
                        active  <= 1'b1;
                        r_pre   <= '0;
                        r_bit   <= '0;
                        sr_clk  <= 1'b0;
                        sr_mosi <= r_sh[c_sr_w-1];
                        r_sh    <= {r_sh[c_sr_w-2:0], 1'b0};
                    end
                end

                ST_SHIFT: begin
                    if (!spi_gnt) begin
                        r_state <= ST_IDLE;
                        spi_req <= 1'b0;
                        sr_clk  <= 1'b0;
                        sr_mosi <= 1'b0;
                        active  <= 1'b0;
                    end else if (r_pre == c_half_last) begin
                        r_pre <= '0;
                        if (!sr_clk) begin
                            sr_clk <= 1'b1;
                        end else begin
                            sr_clk <= 1'b0;
                            if (r_bit == c_bit_last) begin
                                r_state <= ST_LATCH;
                                sr_mosi <= 1'b0;
                                sr_rclk <= 1'b1;
                            end else begin
                                r_bit   <= r_bit + 1'b1;
                                sr_mosi <= r_sh[c_sr_w-1];
                                r_sh    <= {r_sh[c_sr_w-2:0], 1'b0};
                            end
                        end
                    end else begin
                        r_pre <= r_pre + 1'b1;
                    end
                end

                ST_LATCH: begin
                    if (!spi_gnt) begin
                        r_state <= ST_IDLE;
                        spi_req <= 1'b0;
                        sr_rclk <= 1'b0;
                        sr_mosi <= 1'b0;
                        active  <= 1'b0;
                    end else if (r_pre == c_latch_last) begin
                        r_state <= ST_DONE;
                        r_pre   <= '0;
                        spi_req <= 1'b0;
                        sr_rclk <= 1'b0;
                        sr_mosi <= 1'b0;
                        active  <= 1'b0;
                    end else begin
                        r_pre <= r_pre + 1'b1;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    led_sr_btn_deb #(
        .BTN_DEB (BTN_DEB)
    ) u_btn_deb (
        .clk       (clk),
        .rst       (rst),
        .sample_en (w_btn_sample),
        .btn_in    (btn_in),
        .btn_val   (btn_val),
        .btn_stb   (btn_stb)
    );

endmodule
`default_nettype wire
